// File: rtl/regbank_pkg.sv
// Shared definitions for the register bank reader-side dump controller.
//   NREGS : number of registers in the bank (even, >= 2)
//   DW    : register / stream data width
//   AW    : register index width, clog2(NREGS)
//   dump_state_t : dump controller state encoding
package regbank_pkg;

  localparam int NREGS = 32;
  localparam int DW    = 32;
  localparam int AW    = 5;

  typedef enum logic [2:0] {
    IDLE,
    CAPT,
    SEND0,
    SEND1,
    FIN
  } dump_state_t;

endpackage

// File: rtl/regbank_dump_ctrl.sv
// Reader-side dump controller for the register bank.
// Walks the bank two registers at a time (sr1 = even, sr2 = odd index),
// captures both words in one cycle and streams them out in index order over
// a valid/ready interface. Optionally zeroes each register after capture
// through the bank write port.
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; all outputs quiet
// CAPT  | sr1/sr2 drive pair p; data captured on exit; zero reg 2p if clr
// SEND0 | present even word 2p; zero reg 2p+1 on the first cycle if clr
// SEND1 | present odd word 2p+1; advance to next pair or finish
// FIN   | one-cycle done pulse, busy falls on exit
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, clr_en       dump request and clear-after-capture option
//   sr1, sr2            bank read addresses (driven only in CAPT)
//   rdData1, rdData2    combinational bank read data
//   wr_en, wr_addr,
//   wr_data             bank write port used for zeroing (data always 0)
//   out_valid, out_ready,
//   out_data, out_idx,
//   out_last            output word stream
//   busy, done          status
module regbank_dump_ctrl
  import regbank_pkg::*;
#(
  parameter int NREGS = regbank_pkg::NREGS,
  parameter int DW    = regbank_pkg::DW,
  parameter int AW    = regbank_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          clr_en,
  output logic [AW-1:0] sr1,
  output logic [AW-1:0] sr2,
  input  logic [DW-1:0] rdData1,
  input  logic [DW-1:0] rdData2,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam int            PW     = AW - 1;
  localparam logic [PW-1:0] P_LAST = PW'(NREGS / 2 - 1);

  dump_state_t   state;
  logic [PW-1:0] p;
  logic [PW-1:0] p_next;
  logic          clr_flag;
  logic [DW-1:0] buf1;

  assign p_next  = p + PW'(1);
  assign wr_data = '0;

  // All outputs are registered: each transition loads the values the next
  // state must present, so outputs are valid from the first cycle of a state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      p         <= '0;
      clr_flag  <= 1'b0;
      buf1      <= '0;
      sr1       <= '0;
      sr2       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CAPT;
            p        <= '0;
            clr_flag <= clr_en;
            busy     <= 1'b1;
            sr1      <= '0;
            sr2      <= AW'(1);
            wr_en    <= clr_en;
            wr_addr  <= '0;
          end
        end

        CAPT: begin
          // Even word goes straight to the output register; odd word waits.
          // The bank write of reg 2p lands on this same edge, so the
          // captured value is the pre-clear content.
          out_data  <= rdData1;
          buf1      <= rdData2;
          out_valid <= 1'b1;
          out_idx   <= {p, 1'b0};
          out_last  <= 1'b0;
          sr1       <= '0;
          sr2       <= '0;
          wr_en     <= clr_flag;
          wr_addr   <= {p, 1'b1};
          state     <= SEND0;
        end

        SEND0: begin
          // Odd register is zeroed on the first SEND0 cycle only.
          wr_en   <= 1'b0;
          wr_addr <= '0;
          if (out_ready) begin
            out_data <= buf1;
            out_idx  <= {p, 1'b1};
            out_last <= (p == P_LAST);
            state    <= SEND1;
          end
        end

        SEND1: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              p       <= p_next;
              sr1     <= {p_next, 1'b0};
              sr2     <= {p_next, 1'b1};
              wr_en   <= clr_flag;
              wr_addr <= {p_next, 1'b0};
              state   <= CAPT;
            end
          end
        end

        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_dump_ctrl.sv
// Self-checking bench for regbank_dump_ctrl. A behavioural 32x32 register
// bank is attached; its write port is muxed between the DUT, a bench write
// port and a bulk preload. Expected words are queued at stimulus time and a
// negedge monitor pops and compares on every handshake.
module tb_regbank_dump_ctrl;

  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, clr_en;
  logic [4:0]  sr1, sr2;
  logic [31:0] rd1, rd2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        out_valid, out_ready, out_last, busy, done;
  logic [31:0] out_data;
  logic [4:0]  out_idx;

  always #5 clk = ~clk;

  regbank_dump_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .clr_en(clr_en),
    .sr1(sr1), .sr2(sr2), .rdData1(rd1), .rdData2(rd2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  // ---------------- register bank model ----------------
  logic [31:0] bank [NR];
  logic        do_preload = 1'b0;
  logic        tb_we = 1'b0;
  logic [4:0]  tb_waddr = '0;
  logic [31:0] tb_wdata = '0;

  assign rd1 = bank[sr1];
  assign rd2 = bank[sr2];

  always @(posedge clk) begin
    if (do_preload) begin
      for (int k = 0; k < NR; k++) bank[k] <= 32'hA5A50000 + k;
    end else if (wr_en) begin
      bank[wr_addr] <= wr_data;
    end else if (tb_we) begin
      bank[tb_waddr] <= tb_wdata;
    end
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] expv [NR];

  int          cyc = 0;
  int          words, wr_cnt, done_cnt, last_hs_cyc;
  logic [4:0]  wr_exp;
  logic        prev_stall = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] hold_data;
  logic [4:0]  hold_idx;
  logic        hold_last;
  logic        bp_mode = 1'b0;
  int          rc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {out_valid, out_last, out_idx, out_data},
            {1'b1, hold_last, hold_idx, hold_data});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got idx %0d data %h, required no word", out_idx, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("word", {out_last, out_idx, out_data}, {e.last, e.idx, e.data});
          words++;
          if (out_last) last_hs_cyc = cyc;
        end
      end
      prev_stall = out_valid && !out_ready;
      hold_data  = out_data;
      hold_idx   = out_idx;
      hold_last  = out_last;
      if (wr_en) begin
        chk("wr_port", {wr_data, 3'b0, wr_addr}, {32'h0, 3'b0, wr_exp});
        wr_exp = wr_exp + 5'd1;
        wr_cnt++;
      end
      if (done) begin
        chk("done_after_last", 64'(cyc), 64'(last_hs_cyc + 1));
        chk("done_one_cycle", 64'(prev_done), 64'h0);
        done_cnt++;
      end
      prev_done = done;
    end
  end

  // ---------------- consumer ready driver ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        out_ready = (rc % 4 == 0) || (rc % 4 == 3);  // 1-0-0-1 pattern
        rc++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // ---------------- helper tasks ----------------
  task automatic preload();
    @(posedge clk); #1 do_preload = 1'b1;
    @(posedge clk); #1 do_preload = 1'b0;
  endtask

  task automatic set_exp_preload();
    for (int k = 0; k < NR; k++) expv[k] = 32'hA5A50000 + k;
  endtask

  task automatic push_expected();
    exp_t x;
    for (int k = 0; k < NR; k++) begin
      x.idx  = 5'(k);
      x.data = expv[k];
      x.last = (k == NR - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic reset_counters();
    words    = 0;
    wr_cnt   = 0;
    wr_exp   = '0;
    done_cnt = 0;
    last_hs_cyc = -10;
  endtask

  task automatic start_dump(input logic clr);
    @(posedge clk); #1 start = 1'b1; clr_en = clr;
    @(posedge clk); #1 start = 1'b0; clr_en = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done", budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_end(input string name, input int exp_words, input int exp_wr);
    chk({name, "_words"}, 64'(words), 64'(exp_words));
    chk({name, "_wr_count"}, 64'(wr_cnt), 64'(exp_wr));
    chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'h0);
    chk({name, "_done_count"}, 64'(done_cnt), 64'h1);
  endtask

  task automatic check_bank(input string name);
    for (int k = 0; k < NR; k++) chk({name, "_bank"}, {27'h0, 5'(k), bank[k]}, {27'h0, 5'(k), expv[k]});
  endtask

  task automatic check_outputs_zero(input string name);
    chk(name, {sr1, sr2, wr_en, wr_addr, out_valid, out_data, out_idx, out_last, busy, done}, 64'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int busy_drop;
    rst = 1'b1;
    start = 1'b0;
    clr_en = 1'b0;
    reset_counters();
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset_outputs");
    rst = 1'b0;

    // 1: plain dump, no clear
    preload();
    set_exp_preload();
    reset_counters();
    push_expected();
    start_dump(1'b0);
    wait_done(1000);
    check_end("plain", 32, 0);
    check_bank("plain");

    // 2: dump with clear
    preload();
    set_exp_preload();
    reset_counters();
    push_expected();
    start_dump(1'b1);
    wait_done(1000);
    check_end("clear", 32, 32);
    for (int k = 0; k < NR; k++) expv[k] = 32'h0;
    check_bank("clear");

    // 3: backpressure and first-word latency
    preload();
    set_exp_preload();
    reset_counters();
    push_expected();
    rc = 0;
    bp_mode = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("capt_cycle", {out_valid, busy}, {1'b0, 1'b1});
    @(negedge clk);
    chk("first_valid", {out_valid, out_idx}, {1'b1, 5'd0});
    wait_done(2000);
    bp_mode = 1'b0;
    check_end("bp", 32, 0);

    // 4: start while busy and in FIN is ignored
    preload();
    set_exp_preload();
    reset_counters();
    push_expected();
    start_dump(1'b0);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    busy_drop = 0;
    n = 0;
    do begin
      @(negedge clk);
      if (!busy) busy_drop++;
      n++;
    end while (!done && n < 1000);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_continuous", 64'(busy_drop), 64'h0);
    @(negedge clk);
    chk("fin_start_ignored", {busy, out_valid}, 2'b00);
    repeat (3) @(negedge clk);
    chk("no_second_dump", {busy, out_valid}, 2'b00);
    check_end("restart", 32, 0);

    // 5: reset mid-dump with clear
    preload();
    set_exp_preload();
    reset_counters();
    push_expected();
    start_dump(1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_ready && out_idx == 5'd9) && n < 500);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_reset_outputs");
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_words", 64'(words), 64'd10);
    chk("abort_wr_count", 64'(wr_cnt), 64'd11);
    chk("abort_no_done", 64'(done_cnt), 64'h0);
    for (int k = 0; k < NR; k++) expv[k] = (k <= 10) ? 32'h0 : 32'hA5A50000 + k;
    check_bank("abort");
    reset_counters();
    push_expected();
    start_dump(1'b0);
    wait_done(1000);
    check_end("after_reset", 32, 0);

    // 6: foreign write to a later register is visible
    preload();
    set_exp_preload();
    expv[20] = 32'hDEADBEEF;
    reset_counters();
    push_expected();
    start_dump(1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_idx == 5'd4) && n < 500);
    tb_we = 1'b1; tb_waddr = 5'd20; tb_wdata = 32'hDEADBEEF;
    @(posedge clk); #1 tb_we = 1'b0;
    wait_done(1000);
    check_end("foreign", 32, 0);
    check_bank("foreign");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
